uart_rx: RTL

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_pkg.sv | 8 +
 rtl/sync_2ff.sv | 16 +
 rtl/uart_rx.sv | 96 +++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: receiver state encoding and baud-timing defaults shared by the UART blocks
package uart_pkg;
  typedef enum logic [2:0] {ARM, IDLE, START, DATA, STOP, BREAK} uart_state_e;
  localparam int CLKS_PER_BIT_DEF = 5208;
  function automatic int half_bit(input int clks);
    return clks / 2 - 1;
  endfunction
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for an asynchronous input, resetting to the idle-high level
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic [1:0] sync_q, sync_d;
  // shift the raw input through two stages
  always_comb sync_d = {sync_q[0], d};
  // synchronizer register, reset to the line's idle level
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sync_q <= 2'b11;
    else sync_q <= sync_d;
  assign q = sync_q[1];
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with mid-bit sampling, framing-error detection and arm-after-reset
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int HALF_BIT     = half_bit(CLKS_PER_BIT)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_line,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       busy
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(HALF_BIT);
  // the synchronizer still holds its reset 1s for two edges, so ARM waits this long before trusting rx_s
  localparam logic [CW-1:0] ARM_WAIT = CW'(2);
  uart_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] sh_q, sh_d, data_q, data_d;
  logic valid_q, valid_d, ferr_q, ferr_d;
  logic rx_s;
  sync_2ff u_sync (.clk(clk), .rst_n(rst_n), .d(rx_line), .q(rx_s));
  // next-state, baud/bit counting and byte assembly
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      ARM: begin
        cnt_d = (cnt_q == ARM_WAIT) ? cnt_q : cnt_q + CW'(1);
        if (cnt_q == ARM_WAIT && rx_s) state_d = IDLE;
      end
      IDLE:
        if (!rx_s) begin
          state_d = START;
          cnt_d   = CW'(1);
          bit_d   = 3'd0;
        end
      START:
        if (cnt_q == CNT_HALF) begin
          cnt_d   = '0;
          state_d = rx_s ? IDLE : DATA;
        end else cnt_d = cnt_q + CW'(1);
      DATA:
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          sh_d  = {rx_s, sh_q[7:1]};
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = STOP;
        end else cnt_d = cnt_q + CW'(1);
      STOP:
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = rx_s ? IDLE : BREAK;
          data_d  = rx_s ? sh_q : data_q;
          valid_d = rx_s;
          ferr_d  = !rx_s;
        end else cnt_d = cnt_q + CW'(1);
      BREAK:
        if (rx_s) state_d = IDLE;
      default: state_d = ARM;
    endcase
  end
  // state and datapath registers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= ARM;
      cnt_q   <= '0;
      bit_q   <= 3'd0;
      sh_q    <= 8'h00;
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  assign rx_data   = data_q;
  assign rx_valid  = valid_q;
  assign frame_err = ferr_q;
  assign busy      = state_q != IDLE && state_q != ARM;
endmodule
